// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter that shares the udp core's single transmit interface between two
// packet sources, with a minimum inter-packet gap and a SEND watchdog.
module udp_tx_arbiter #(
  parameter logic [15:0] MAX_BYTES   = 16'd1472,
  parameter int          IFG_CYCLES  = 16,
  parameter logic [23:0] TIMEOUT_CYC = 24'd200000
) (
  input  logic        gmii_tx_clk,
  input  logic        rst_n,
  input  logic [1:0]  src_req,
  input  logic [31:0] src_byte_num,
  input  logic [15:0] src_data,
  output logic [1:0]  src_rd_en,
  output logic [1:0]  src_grant,
  output logic [1:0]  src_done,
  output logic [1:0]  src_err,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

  localparam logic [15:0] IFG_LAST  = 16'(IFG_CYCLES - 1);
  localparam logic [23:0] WDOG_LAST = TIMEOUT_CYC - 24'd1;

  state_t      state;
  logic        g;        // index of the source being served
  logic        ptr;      // source favoured when both request
  logic        rd_q;     // a byte was strobed last cycle, so src_data is valid now
  logic [15:0] len;
  logic [15:0] sent;
  logic [15:0] ifg;
  logic [23:0] wdog;

  logic        pick_g;
  logic [15:0] pick_len;

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    pick_g = src_req[1];
    if (src_req == 2'b11) pick_g = ptr;
    pick_len = pick_g ? src_byte_num[31:16] : src_byte_num[15:0];
  end

  // Strobes stop once len bytes have gone out, even if the udp core keeps asking.
  always_comb begin
    src_rd_en = 2'b00;
    if (state == SEND && tx_req && sent < len) src_rd_en[g] = 1'b1;
  end

  assign tx_data = (rd_q && src_grant[g]) ? (g ? src_data[15:8] : src_data[7:0]) : 8'h00;
  assign busy    = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= 1'b0;
      ptr         <= 1'b0;
      rd_q        <= 1'b0;
      len         <= '0;
      sent        <= '0;
      ifg         <= '0;
      wdog        <= '0;
      src_grant   <= 2'b00;
      src_done    <= 2'b00;
      src_err     <= 2'b00;
      tx_start_en <= 1'b0;
      tx_byte_num <= '0;
    end else begin
      tx_start_en <= 1'b0;
      src_done    <= 2'b00;
      src_err     <= 2'b00;
      rd_q        <= |src_rd_en;
      case (state)
        IDLE: begin
          if (|src_req) begin
            g   <= pick_g;
            len <= pick_len;
            ifg <= '0;
            if (pick_len == 16'd0) begin
              src_done[pick_g] <= 1'b1;
              state            <= GAP;
            end else if (pick_len > MAX_BYTES) begin
              src_err[pick_g] <= 1'b1;
              state           <= GAP;
            end else begin
              src_grant[pick_g] <= 1'b1;
              tx_byte_num       <= pick_len;
              state             <= START;
            end
          end
        end
        START: begin
          tx_start_en <= 1'b1;
          sent        <= '0;
          wdog        <= '0;
          state       <= SEND;
        end
        SEND: begin
          wdog <= wdog + 24'd1;
          if (|src_rd_en) sent <= sent + 16'd1;
          // tx_done takes precedence over a watchdog expiry in the same cycle.
          if (tx_done) begin
            src_done[g] <= 1'b1;
            src_grant   <= 2'b00;
            ifg         <= '0;
            state       <= GAP;
          end else if (wdog == WDOG_LAST) begin
            src_err[g] <= 1'b1;
            src_grant  <= 2'b00;
            ifg        <= '0;
            state      <= GAP;
          end
        end
        GAP: begin
          if (ifg == IFG_LAST) begin
            ptr   <= ~g;
            state <= IDLE;
          end else begin
            ifg <= ifg + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: udp core and source buffer models, an event
// monitor, and a round-robin reference model predicting service order and outcomes.
module tb_udp_tx_arbiter;

  localparam int MAX     = 1472;
  localparam int IFG     = 16;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  src_req = 2'b00;
  logic [31:0] src_byte_num = '0;
  logic [15:0] src_data = '0;
  logic        tx_req = 1'b0;
  logic        tx_done = 1'b0;
  logic [1:0]  src_rd_en, src_grant, src_done, src_err;
  logic        tx_start_en, busy;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data;

  udp_tx_arbiter #(
    .MAX_BYTES  (16'(MAX)),
    .IFG_CYCLES (IFG),
    .TIMEOUT_CYC(24'(TIMEOUT))
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .src_req     (src_req),
    .src_byte_num(src_byte_num),
    .src_data    (src_data),
    .src_rd_en   (src_rd_en),
    .src_grant   (src_grant),
    .src_done    (src_done),
    .src_err     (src_err),
    .tx_start_en (tx_start_en),
    .tx_byte_num (tx_byte_num),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_done     (tx_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- udp core model ----------------
  int udp_extra   = 0;   // tx_req beyond tx_byte_num
  bit udp_omit    = 0;   // never send tx_done
  int udp_done_at = 0;   // fixed tx_done offset from start pulse, 0 = two cycles after last req

  always begin
    @(negedge clk);
    if (rst_n && tx_start_en) begin
      int n, d, last;
      n = int'(tx_byte_num) + udp_extra;
      d = udp_omit ? -1 : (udp_done_at > 0 ? udp_done_at : n + 2);
      last = ((d > n) ? d : n) + 1;
      for (int k = 1; k <= last; k++) begin
        @(posedge clk); #1;
        if (!rst_n) break;
        tx_req  = (k <= n);
        tx_done = (k == d);
      end
      tx_req  = 1'b0;
      tx_done = 1'b0;
    end
  end

  // ---------------- source buffer model ----------------
  logic [7:0] mem [2][256];
  int         rdcnt [2] = '{0, 0};
  logic [1:0] pend_rd = 2'b00;

  always @(negedge clk) pend_rd = src_rd_en;

  always @(posedge clk) begin
    #1;
    for (int s = 0; s < 2; s++)
      if (pend_rd[s]) begin
        src_data[s*8 +: 8] = mem[s][rdcnt[s] % 256];
        rdcnt[s]++;
      end
  end

  // ---------------- monitor ----------------
  typedef struct { int cyc; int len; logic [1:0] grant; } start_t;
  typedef struct { int cyc; int src; bit err; } ret_t;

  start_t     start_q[$];
  ret_t       ret_q[$];
  logic [7:0] data_q[$];
  int         str_cnt [2] = '{0, 0};
  int         ret_cnt [2] = '{0, 0};
  logic       prev_req = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (tx_start_en) start_q.push_back('{cyc, int'(tx_byte_num), src_grant});
      if (prev_req) data_q.push_back(tx_data);
      prev_req = tx_req;
      for (int s = 0; s < 2; s++) begin
        if (src_rd_en[s]) str_cnt[s]++;
        if (src_done[s]) begin ret_q.push_back('{cyc, s, 1'b0}); ret_cnt[s]++; end
        if (src_err[s])  begin ret_q.push_back('{cyc, s, 1'b1}); ret_cnt[s]++; end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int ret_seen [2] = '{0, 0};
  int m_ret, m_start, m_data, t_req;
  int m_str [2];
  int m_base [2];
  int r_len [2];

  // A source drops its request once it sees its done/err pulse.
  task automatic tick();
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++)
      if (ret_cnt[s] != ret_seen[s]) begin
        ret_seen[s] = ret_cnt[s];
        src_req[s]  = 1'b0;
      end
  endtask

  task automatic fill_mem(input int s, input int base, input int len);
    for (int i = 0; i < ((len < 64) ? len : 64); i++) mem[s][(base + i) % 256] = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0 && src_req == 2'b00) begin ok = 1; break; end
      tick();
    end
  endtask

  task automatic run_round(input logic [1:0] mask, input int l0, input int l1,
                           input int rereq_s, output bit ok);
    int need, rc0;
    bit re_done;
    wait_idle(400, ok);
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_wait: busy=%b src_req=%b required idle", busy, src_req);
      return;
    end
    m_ret = ret_q.size(); m_start = start_q.size(); m_data = data_q.size();
    for (int s = 0; s < 2; s++) begin m_str[s] = str_cnt[s]; m_base[s] = rdcnt[s]; end
    r_len[0] = l0; r_len[1] = l1;
    src_byte_num = {16'(l1), 16'(l0)};
    for (int s = 0; s < 2; s++) if (mask[s]) fill_mem(s, m_base[s], r_len[s]);
    rc0 = (rereq_s >= 0) ? ret_cnt[rereq_s] : 0;
    src_req = mask;
    t_req   = cyc;
    need    = $countones(mask) + ((rereq_s >= 0) ? 1 : 0);
    re_done = 0;
    ok      = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rereq_s >= 0 && !re_done && ret_cnt[rereq_s] != rc0) begin
        re_done = 1;
        fill_mem(rereq_s, rdcnt[rereq_s], r_len[rereq_s]);
        src_req[rereq_s] = 1'b1;
      end
      if (ret_q.size() - m_ret >= need) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL round_timeout: retired %0d required %0d", ret_q.size() - m_ret, need);
    end
  endtask

  // ---------------- reference model ----------------
  int model_ptr = 0;
  int exp_order[$];

  // Serve pending sources one at a time; on contention take the favoured one, then favour
  // the other. A re-request rejoins the pending set after its first service.
  task automatic model_predict(input logic [1:0] mask, input int rereq_s);
    logic [1:0] pend;
    bit re;
    pend = mask;
    re   = (rereq_s >= 0);
    exp_order.delete();
    while (pend != 2'b00) begin
      int pick;
      if (pend == 2'b11) pick = model_ptr;
      else pick = pend[1] ? 1 : 0;
      exp_order.push_back(pick);
      pend[pick] = 1'b0;
      model_ptr  = 1 - pick;
      if (re && pick == rereq_s) begin re = 0; pend[pick] = 1'b1; end
    end
  endtask

  function automatic bit started(input int len);
    return len > 0 && len <= MAX;
  endfunction

  function automatic logic [37:0] all_outs();
    return {src_rd_en, src_grant, src_done, src_err, tx_start_en, tx_byte_num, tx_data, busy};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    rst_n = 1'b1;
    model_ptr = 0;
    repeat (4) tick();
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL idle_outputs: got %h required 0", all_outs());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    model_predict(2'b11, 0);
    run_round(2'b11, 4, 4, 0, ok);
    if (!ok) return;
    n_cmp++;
    if (ret_q[m_ret].src != 0) begin
      n_bad++; $display("FAIL b2b_first: got src%0d required src0", ret_q[m_ret].src);
    end
    for (int i = 0; i < exp_order.size(); i++) begin
      n_cmp++;
      if (ret_q[m_ret + i].src != exp_order[i] || ret_q[m_ret + i].err) begin
        n_bad++;
        $display("FAIL b2b_order[%0d]: got src%0d err=%0b required src%0d done",
                 i, ret_q[m_ret + i].src, ret_q[m_ret + i].err, exp_order[i]);
      end
    end
    n_cmp++;
    if (start_q.size() - m_start != 3) begin
      n_bad++; $display("FAIL b2b_starts: got %0d required 3", start_q.size() - m_start);
    end else begin
      n_cmp++;
      if (start_q[m_start].cyc - t_req != 2) begin
        n_bad++; $display("FAIL b2b_latency: got %0d required 2", start_q[m_start].cyc - t_req);
      end
      for (int i = 1; i < 3; i++) begin
        n_cmp++;
        if (start_q[m_start + i].cyc - ret_q[m_ret + i - 1].cyc < IFG ||
            start_q[m_start + i].cyc - start_q[m_start + i - 1].cyc < 4 + IFG) begin
          n_bad++;
          $display("FAIL b2b_gap[%0d]: start at %0d after done at %0d, required >= %0d apart",
                   i, start_q[m_start + i].cyc, ret_q[m_ret + i - 1].cyc, IFG);
        end
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    int bad;
    model_predict(2'b01, -1);
    run_round(2'b01, 4, 0, -1, ok);
    if (!ok) return;
    n_cmp++;
    if (start_q.size() - m_start != 1) begin
      n_bad++; $display("FAIL single_starts: got %0d required 1", start_q.size() - m_start);
      return;
    end
    n_cmp++;
    if (start_q[m_start].cyc - t_req != 2) begin
      n_bad++; $display("FAIL single_latency: got %0d required 2", start_q[m_start].cyc - t_req);
    end
    n_cmp++;
    if (start_q[m_start].len != 4 || start_q[m_start].grant !== 2'b01) begin
      n_bad++;
      $display("FAIL single_start_info: len=%0d grant=%b required 4/01",
               start_q[m_start].len, start_q[m_start].grant);
    end
    n_cmp++;
    if (str_cnt[0] - m_str[0] != 4 || str_cnt[1] - m_str[1] != 0) begin
      n_bad++;
      $display("FAIL single_strobes: got %0d/%0d required 4/0",
               str_cnt[0] - m_str[0], str_cnt[1] - m_str[1]);
    end
    bad = (data_q.size() - m_data != 4) ? 1 : 0;
    for (int i = 0; i < 4 && !bad; i++)
      if (data_q[m_data + i] !== mem[0][(m_base[0] + i) % 256]) bad++;
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL single_data: %0d byte(s)/count wrong, got %0d bytes required 4",
                        bad, data_q.size() - m_data);
    end
    n_cmp++;
    if (ret_q[m_ret].src != 0 || ret_q[m_ret].err || ret_q[m_ret].cyc != start_q[m_start].cyc + 7) begin
      n_bad++;
      $display("FAIL single_done: src%0d err=%0b at +%0d required src0 done at +7",
               ret_q[m_ret].src, ret_q[m_ret].err, ret_q[m_ret].cyc - start_q[m_start].cyc);
    end
  endtask

  task automatic test_zero_oversize();
    bit ok;
    int lens [3] = '{0, 1500, 1473};
    int srcs [3] = '{1, 0, 1};
    for (int t = 0; t < 3; t++) begin
      model_predict(2'(1 << srcs[t]), -1);
      run_round(2'(1 << srcs[t]), srcs[t] == 0 ? lens[t] : 0, srcs[t] == 1 ? lens[t] : 0, -1, ok);
      if (!ok) continue;
      n_cmp++;
      if (start_q.size() != m_start || str_cnt[srcs[t]] != m_str[srcs[t]]) begin
        n_bad++; $display("FAIL no_start_len%0d: got %0d start(s) required 0",
                          lens[t], start_q.size() - m_start);
      end
      n_cmp++;
      if (ret_q[m_ret].src != srcs[t] || ret_q[m_ret].err != (lens[t] > MAX) ||
          ret_q[m_ret].cyc != t_req + 1) begin
        n_bad++;
        $display("FAIL retire_len%0d: src%0d err=%0b at +%0d required src%0d err=%0b at +1",
                 lens[t], ret_q[m_ret].src, ret_q[m_ret].err, ret_q[m_ret].cyc - t_req,
                 srcs[t], lens[t] > MAX);
      end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    udp_omit = 1;
    model_predict(2'b01, -1);
    run_round(2'b01, 4, 0, -1, ok);
    udp_omit = 0;
    if (ok) begin
      n_cmp++;
      if (start_q.size() - m_start != 1 || ret_q[m_ret].src != 0 || !ret_q[m_ret].err ||
          ret_q[m_ret].cyc - start_q[m_start].cyc != TIMEOUT) begin
        n_bad++;
        $display("FAIL watchdog_abort: src%0d err=%0b at +%0d required src0 err at +%0d",
                 ret_q[m_ret].src, ret_q[m_ret].err, ret_q[m_ret].cyc - start_q[m_start].cyc, TIMEOUT);
      end
    end
    model_predict(2'b10, -1);
    run_round(2'b10, 0, 3, -1, ok);
    if (!ok) return;
    n_cmp++;
    if (ret_q[m_ret].src != 1 || ret_q[m_ret].err || str_cnt[1] - m_str[1] != 3) begin
      n_bad++;
      $display("FAIL after_watchdog: src%0d err=%0b strobes=%0d required src1 done strobes=3",
               ret_q[m_ret].src, ret_q[m_ret].err, str_cnt[1] - m_str[1]);
    end
  endtask

  task automatic test_extra_req();
    bit ok;
    int bad;
    udp_extra = 2;
    model_predict(2'b01, -1);
    run_round(2'b01, 4, 0, -1, ok);
    udp_extra = 0;
    if (ok) begin
      n_cmp++;
      if (str_cnt[0] - m_str[0] != 4) begin
        n_bad++; $display("FAIL extra_strobes: got %0d required 4", str_cnt[0] - m_str[0]);
      end
      bad = (data_q.size() - m_data != 6) ? 1 : 0;
      for (int i = 0; i < 6 && !bad; i++)
        if (data_q[m_data + i] !== ((i < 4) ? mem[0][(m_base[0] + i) % 256] : 8'h00)) bad++;
      n_cmp++;
      if (bad != 0) begin
        n_bad++; $display("FAIL extra_data: got %0d bytes, %0d wrong, required 4 bytes then 2 zeros",
                          data_q.size() - m_data, bad);
      end
    end
    udp_done_at = TIMEOUT - 1;
    model_predict(2'b10, -1);
    run_round(2'b10, 0, 3, -1, ok);
    udp_done_at = 0;
    if (!ok) return;
    repeat (2) tick();
    n_cmp++;
    if (ret_q.size() - m_ret != 1 || ret_q[m_ret].src != 1 || ret_q[m_ret].err ||
        ret_q[m_ret].cyc - start_q[m_start].cyc != TIMEOUT) begin
      n_bad++;
      $display("FAIL done_vs_wdog: %0d retire(s), first src%0d err=%0b at +%0d required one src1 done at +%0d",
               ret_q.size() - m_ret, ret_q[m_ret].src, ret_q[m_ret].err,
               ret_q[m_ret].cyc - start_q[m_start].cyc, TIMEOUT);
    end
  endtask

  task automatic test_random_traffic();
    bit ok;
    for (int r = 0; r < 14; r++) begin
      logic [1:0] mask;
      int l [2];
      int n_st, bad, di, str_exp [2];
      mask = 2'($urandom_range(1, 3));
      for (int s = 0; s < 2; s++) begin
        int p = $urandom_range(0, 9);
        l[s] = (p == 0) ? 0 : (p == 1) ? MAX + 1 + $urandom_range(0, 100) : $urandom_range(1, 20);
        if (!mask[s]) l[s] = 0;
      end
      udp_extra = $urandom_range(0, 2);
      model_predict(mask, -1);
      run_round(mask, l[0], l[1], -1, ok);
      if (!ok) continue;
      bad = 0; n_st = 0; di = m_data; str_exp = '{0, 0};
      for (int i = 0; i < exp_order.size(); i++) begin
        int s = exp_order[i];
        if (ret_q[m_ret + i].src != s || ret_q[m_ret + i].err != (l[s] > MAX)) bad++;
        if (started(l[s])) begin
          if (start_q.size() <= m_start + n_st || start_q[m_start + n_st].len != l[s] ||
              start_q[m_start + n_st].grant !== 2'(1 << s)) bad++;
          n_st++;
          str_exp[s] = l[s];
          for (int k = 0; k < l[s] + udp_extra; k++) begin
            if (di >= data_q.size() ||
                data_q[di] !== ((k < l[s]) ? mem[s][(m_base[s] + k) % 256] : 8'h00)) bad++;
            di++;
          end
        end
      end
      n_cmp++;
      if (bad != 0 || start_q.size() - m_start != n_st || data_q.size() != di ||
          str_cnt[0] - m_str[0] != str_exp[0] || str_cnt[1] - m_str[1] != str_exp[1]) begin
        n_bad++;
        $display("FAIL random_round%0d: mask=%b len=%0d/%0d %0d field error(s), starts %0d required %0d, strobes %0d/%0d required %0d/%0d",
                 r, mask, l[0], l[1], bad, start_q.size() - m_start, n_st,
                 str_cnt[0] - m_str[0], str_cnt[1] - m_str[1], str_exp[0], str_exp[1]);
      end
    end
    udp_extra = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_idle(400, ok);
    m_ret = ret_q.size(); m_start = start_q.size();
    src_byte_num = {16'd12, 16'd5};
    fill_mem(1, rdcnt[1], 12);
    src_req = 2'b10;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (start_q.size() > m_start) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL mid_start: no tx_start_en within 60 cycles, required one");
      return;
    end
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outs() !== '0) begin
      n_bad++; $display("FAIL async_reset_outputs: got %h required 0", all_outs());
    end
    n_cmp++;
    if (ret_q.size() != m_ret) begin
      n_bad++; $display("FAIL abort_pulse: got %0d retire(s) required 0", ret_q.size() - m_ret);
    end
    src_req = 2'b11;
    model_ptr = 0;
    model_predict(2'b11, -1);
    repeat (3) tick();
    rst_n = 1'b1;
    m_ret = ret_q.size();
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ret_q.size() - m_ret >= 2) begin ok = 1; break; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL reserve_timeout: retired %0d required 2", ret_q.size() - m_ret);
      return;
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (ret_q[m_ret + i].src != exp_order[i] || ret_q[m_ret + i].err) begin
        n_bad++;
        $display("FAIL reserve_order[%0d]: got src%0d err=%0b required src%0d done",
                 i, ret_q[m_ret + i].src, ret_q[m_ret + i].err, exp_order[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single();
    test_zero_oversize();
    test_watchdog();
    test_extra_req();
    test_random_traffic();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
